serial_alu_sequencer: RTL and testbench

Bit-serial arithmetic controller that runs WIDTH-bit operations through a single 1-bit arithmetic slice, one bit per clock, LSB first. It accepts an operand pair plus the 3-bit function select {s1, s0, ci} over a valid/ready handshake. It conditions the operands per function, threads the carry through a flip-flop between bit-slices, and returns the WIDTH-bit result and final carry over a second valid/ready handshake. It sits between the register-file/control front end and the 1-bit arithmetic slice, letting the team reuse one slice for multi-bit arithmetic.

---
 rtl/serial_alu_sequencer.sv | 130 +++++++++++++
 tb/tb_serial_alu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: runs WIDTH-bit add/subtract functions through one
// full-adder slice, LSB first, between two valid/ready handshakes.
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_s1,
    input  logic             in_s0,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_h,
    output logic             out_co,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [1:0]       sel_reg;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic a_bit;
    logic b_bit;
    logic sum;
    logic cout;
    logic accept;
    logic last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand conditioning: s1s0 = 00 zeroes B, 10 inverts B, 11 inverts A.
    always_comb begin
        a_bit = (sel_reg == 2'b11) ? ~a_reg[0] : a_reg[0];
        case (sel_reg)
            2'b00:   b_bit = 1'b0;
            2'b10:   b_bit = ~b_reg[0];
            default: b_bit = b_reg[0];
        endcase
        sum      = a_bit ^ b_bit ^ carry;
        cout     = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
        accept   = (state == IDLE) && in_valid;
        last_bit = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            shift_reg <= '0;
            sel_reg   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            out_h     <= '0;
            out_co    <= 1'b0;
        end else if (accept) begin
            // The carry-in select bit is the initial carry for every function.
            a_reg     <= in_a;
            b_reg     <= in_b;
            shift_reg <= '0;
            sel_reg   <= {in_s1, in_s0};
            cnt       <= '0;
            carry     <= in_ci;
        end else if (state == RUN) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            shift_reg <= {sum, shift_reg[WIDTH-1:1]};
            carry     <= cout;
            if (last_bit) begin
                out_h  <= {sum, shift_reg[WIDTH-1:1]};
                out_co <= cout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized self-checking bench for serial_alu_sequencer against an
// arithmetic reference model of the function table.
module tb_serial_alu_sequencer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_s1;
    logic             in_s0;
    logic             in_ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_h;
    logic             out_co;
    logic             busy;

    int tests_run;
    int tests_failed;

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_s1     (in_s1),
        .in_s0     (in_s0),
        .in_ci     (in_ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .out_co    (out_co),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: {co, h} = A' + B' + ci over WIDTH+1 bits.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] sel);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        case (sel[2:1])
            2'b00:   begin x = a;  y = '0; end
            2'b01:   begin x = a;  y = b;  end
            2'b10:   begin x = a;  y = ~b; end
            default: begin x = ~a; y = b;  end
        endcase
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, sel[0]};
    endfunction

    task automatic waitIdle(output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        if (!ok) checkOutput("idle_timeout", 32'(guard), 32'd0);
    endtask

    // One full operation; hold = cycles of backpressure in DONE, early = out_ready
    // already high before DONE is entered.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] sel, input logic [WIDTH:0] expected,
                                 input int hold, input bit early);
        bit ok;
        int lat;
        int busy_cycles;
        logic [WIDTH-1:0] held_h;
        logic held_co;
        waitIdle(ok);
        if (!ok) return;
        in_a = a;
        in_b = b;
        {in_s1, in_s0, in_ci} = sel;
        in_valid = 1'b1;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        busy_cycles = busy ? 1 : 0;
        lat = 0;
        while (!out_valid && lat < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
        checkOutput("latency", 32'(lat), 32'(WIDTH));
        if (!out_valid) return;
        checkOutput("busy_cycles", 32'(busy_cycles), 32'(WIDTH));
        checkOutput("out_h", 32'(out_h), 32'(expected[WIDTH-1:0]));
        checkOutput("out_co", 32'(out_co), 32'(expected[WIDTH]));
        if (!early) begin
            held_h = out_h;
            held_co = out_co;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = $urandom_range(0, 1);
                in_a = $urandom;
                in_b = $urandom;
                {in_s1, in_s0, in_ci} = 3'($urandom);
                @(posedge clk);
                #1;
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_h", 32'({out_co, out_h}), 32'({held_co, held_h}));
                checkOutput("hold_ready", 32'({in_ready, busy}), 32'd0);
            end
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("release", 32'({in_ready, out_valid, busy}), 32'b100);
        checkOutput("release_h", 32'({out_co, out_h}), 32'(expected));
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2:0] rs;
        int seen_valid;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        {in_s1, in_s0, in_ci} = 3'b000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
        checkOutput("reset_out", 32'({out_co, out_h}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(8'h3C, 8'h05, 3'b011, 9'h042, 2, 1'b0);
        applyStimulus(8'h10, 8'h01, 3'b101, 9'h10F, 0, 1'b0);
        applyStimulus(8'h01, 8'h02, 3'b101, 9'h0FF, 1, 1'b0);
        applyStimulus(8'hFF, 8'h00, 3'b001, 9'h100, 0, 1'b1);
        applyStimulus(8'hFF, 8'hAA, 3'b000, 9'h0FF, 0, 1'b0);
        applyStimulus(8'h05, 8'h03, 3'b110, 9'h0FD, 0, 1'b1);
        applyStimulus(8'h05, 8'h03, 3'b111, 9'h0FE, 0, 1'b0);
        applyStimulus(8'h05, 8'h03, 3'b100, 9'h101, 5, 1'b0);

        $display("[TB] reset during RUN");
        waitIdle(ok);
        if (ok) begin
            in_a = 8'hAB;
            in_b = 8'hCD;
            {in_s1, in_s0, in_ci} = 3'b011;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("rst_run_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
            checkOutput("rst_run_out", 32'({out_co, out_h}), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            seen_valid = 0;
            repeat (WIDTH + 2) begin
                @(posedge clk);
                #1;
                if (out_valid) seen_valid++;
            end
            checkOutput("rst_no_valid", 32'(seen_valid), 32'd0);
        end
        applyStimulus(8'h01, 8'h01, 3'b010, 9'h002, 0, 1'b0);

        $display("[TB] random operations");
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 3'($urandom);
            applyStimulus(ra, rb, rs, model(ra, rb, rs), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
